chord_host_port: RTL
====================

// Module: chord_host_port
// PURPOSE
//  Host-side endpoint of the CORDIC accelerator 32-bit word interface: drives in_interface/valid_in_interface,
//  collects out_interface/valid_out_interface. Accepts pre-packed command words on a valid/ready stream.
//  Credit-limits issue so every result has a guaranteed slot. Buffers results in a FIFO for the bus
//  wrapper. Command/result word formats belong to the accelerator; this block never interprets them.
// PARAMETERS
//  WORD_WIDTH      32   command/result word width (fixed to the accelerator interface)
//  FIFO_DEPTH      8    result FIFO entries; power of two, >=2
//  CNT_WIDTH       4    width of occupancy/outstanding counters; >= clog2(FIFO_DEPTH)+1
//  TIMEOUT_CYCLES  64   watchdog limit; used only with CHORD_HOST_TIMEOUT_EN
// PORTS
//  clk                  in   1          clock
//  reset                in   1          synchronous, active-high reset
//  cmd_valid            in   1          host command word valid
//  cmd_ready            out  1          command accepted when cmd_valid & cmd_ready
//  cmd_data             in   WORD_WIDTH command word
//  in_interface         out  32         word to accelerator
//  valid_in_interface   out  1          one-cycle strobe per issued word
//  out_interface        in   32         result word from accelerator
//  valid_out_interface  in   1          result strobe; accelerator cannot be stalled
//  rsp_valid            out  1          result FIFO non-empty
//  rsp_ready            in   1          host pops head when rsp_valid & rsp_ready
//  rsp_data             out  WORD_WIDTH FIFO head (first-word fall-through)
//  flush                in   1          pulse: stop issue, drain in-flight, discard FIFO
//  busy                 out  1          outstanding != 0 or state != RUN
//  outstanding          out  CNT_WIDTH  words issued, result not yet received
//  err_overflow         out  1          sticky: result arrived with no FIFO slot (word dropped)
//  err_timeout          out  1          sticky watchdog flag (tied 0 without macro)
// BEHAVIOUR
//  - Reset: state=RUN; in_interface=0, valid_in_interface=0, outstanding=0, FIFO empty, rsp_valid=0,
//    errors=0, busy=0, watchdog=0. Reset mid-operation discards in-flight words; late results after reset
//    are counted as unsolicited (see below).
//  - Credit: cmd_ready = (state==RUN) & (outstanding + fifo_count < FIFO_DEPTH). Combinational, no
//    dependence on cmd_valid.
//  - Issue: on accept, next cycle in_interface<=cmd_data, valid_in_interface<=1 for exactly one cycle;
//    in_interface holds its value until the next issue. Latency accept->strobe = 1 cycle. Back-to-back
//    accepts give back-to-back strobes.
//  - outstanding: +1 on accept, -1 on valid_out_interface, unchanged if both in one cycle.
//    valid_out_interface with outstanding==0: unsolicited; word still pushed if space, counter saturates
//    at 0.
//  - FIFO: push on valid_out_interface; pop on rsp_valid&rsp_ready. Push and pop in one cycle when full
//    are both performed. Push when full with no pop: word dropped, err_overflow<=1 (cleared only by reset).
//    Pointers wrap modulo FIFO_DEPTH.
//  - FSM (chord_pkg::host_state_t): RUN -> DRAIN on flush. DRAIN: cmd_ready=0, results still pushed.
//    DRAIN -> CLEAR when outstanding==0. CLEAR (1 cycle): FIFO pointers/count zeroed -> RUN.
//    flush in DRAIN/CLEAR ignored. Pop during CLEAR ignored (rsp_valid forced 0 in CLEAR).
// CONFIGURATION
//  CHORD_HOST_TIMEOUT_EN defined: counter increments each cycle while outstanding!=0 and no result
//  arrives; clears on any result or when outstanding==0. Reaching TIMEOUT_CYCLES sets err_timeout
//  (sticky) and forces outstanding to 0 so DRAIN can exit.
//  Not defined: no counter; err_timeout tied 0. A lost result can stall DRAIN indefinitely.
// STRUCTURE
//  chord_pkg: WORD_WIDTH constant, host_state_t enum {RUN, DRAIN, CLEAR}.
//  Sub-module chord_rsp_fifo: sync FWFT FIFO (push/pop/clear, count, full/empty).
//  Issue register, credit logic, counters and FSM in chord_host_port.
// TESTING
//  1 Reset, then 3 back-to-back cmds 0x11110000/0x22220000/0x33330000: strobes at cycles 1,2,3;
//    outstanding=3.
//  2 FIFO_DEPTH=8, rsp_ready=0, host keeps cmd_valid=1: exactly 8 accepts, then cmd_ready=0.
//    8 results fill FIFO; err_overflow stays 0.
//  3 FIFO full, inject unsolicited result 0xDEADBEEF with rsp_ready=0 -> dropped, err_overflow=1.
//    Repeat with rsp_ready=1 -> pushed, no error.
//  4 Issue 2 cmds, flush the next cycle: cmd_ready=0 until both results return. CLEAR 1 cycle,
//    rsp_valid=0, back in RUN.
//  5 Accept and result in the same cycle at outstanding=2 -> outstanding stays 2. Results popped in
//    arrival order.
//  6 With CHORD_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=64: issue 1, no result -> err_timeout=1 at cycle 64,
//    outstanding=0.

Source files
------------

// File: rtl/chord_pkg.sv
// Shared types and constants for the CORDIC accelerator host port.
package chord_pkg;

    localparam int unsigned WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } host_state_t;

endpackage

// File: rtl/chord_rsp_fifo.sv
// Synchronous first-word-fall-through result FIFO with clear; a push while full
// is accepted only when a pop frees the head slot in the same cycle.
module chord_rsp_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 push,
    input  logic [WIDTH-1:0]     push_data,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_WIDTH'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty & ~clear;
    assign do_push = push & (~full | do_pop) & ~clear;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_WIDTH'(1);
                2'b01:   count <= count - CNT_WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/chord_host_port.sv
// Host-side endpoint of the CORDIC accelerator word interface: credit-limited issue,
// result buffering and flush sequencing. Optional watchdog: CHORD_HOST_TIMEOUT_EN.
module chord_host_port
    import chord_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned CNT_WIDTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WORD_WIDTH-1:0] cmd_data,
    output logic [WORD_WIDTH-1:0] in_interface,
    output logic                  valid_in_interface,
    input  logic [WORD_WIDTH-1:0] out_interface,
    input  logic                  valid_out_interface,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WORD_WIDTH-1:0] rsp_data,
    input  logic                  flush,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  outstanding,
    output logic                  err_overflow,
    output logic                  err_timeout
);

    localparam int unsigned SUM_W = CNT_WIDTH + 1;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two >= 2");
    end
    if (CNT_WIDTH < $clog2(FIFO_DEPTH) + 1) begin : g_bad_cnt
        $error("CNT_WIDTH too small for FIFO_DEPTH");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be >= 2");
    end

    host_state_t          state;
    host_state_t          state_next;
    logic                 credit_ok;
    logic                 fifo_clear;
    logic                 accept;
    logic                 result_ack;
    logic                 pop;
    logic                 timeout_hit;
    logic [SUM_W-1:0]     credit_used;
    logic [CNT_WIDTH-1:0] fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Every issued word reserves a FIFO slot until its result has been popped.
    assign credit_used = SUM_W'(outstanding) + SUM_W'(fifo_count);
    assign credit_ok   = (credit_used < SUM_W'(FIFO_DEPTH));
    assign accept      = cmd_valid & cmd_ready;
    assign result_ack  = valid_out_interface & (outstanding != '0);
    assign pop         = rsp_valid & rsp_ready;
    assign busy        = (outstanding != '0) || (state != RUN);

    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = DRAIN;
            DRAIN:   if (outstanding == '0) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        cmd_ready  = 1'b0;
        fifo_clear = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            RUN: begin
                cmd_ready = credit_ok;
                rsp_valid = ~fifo_empty;
            end
            DRAIN:   rsp_valid  = ~fifo_empty;
            CLEAR:   fifo_clear = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_interface       <= '0;
            valid_in_interface <= 1'b0;
        end else begin
            valid_in_interface <= accept;
            if (accept) in_interface <= cmd_data;
        end
    end

    // Unsolicited results leave the counter at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= '0;
        end else if (timeout_hit) begin
            outstanding <= CNT_WIDTH'(accept);
        end else begin
            case ({accept, result_ack})
                2'b10:   outstanding <= outstanding + CNT_WIDTH'(1);
                2'b01:   outstanding <= outstanding - CNT_WIDTH'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_overflow <= 1'b0;
        end else if (valid_out_interface && fifo_full && !pop && !fifo_clear) begin
            err_overflow <= 1'b1;
        end
    end

`ifdef CHORD_HOST_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    assign timeout_hit = (outstanding != '0) && !valid_out_interface
                         && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Watchdog runs only while results are owed and none is arriving.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            if (outstanding == '0 || valid_out_interface || timeout_hit) wd_cnt <= '0;
            else                                                          wd_cnt <= wd_cnt + WD_W'(1);
            if (timeout_hit) err_timeout <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    chord_rsp_fifo #(
        .WIDTH     (WORD_WIDTH),
        .DEPTH     (FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (fifo_clear),
        .push      (valid_out_interface),
        .push_data (out_interface),
        .pop       (pop),
        .head      (rsp_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule
